// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: unsigned restoring divider, one quotient bit per clock.
// Each step is a trial subtract (A + ~D + 1); the adder carry-out is the no-borrow flag.
module seq_restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_work_q, q_work_d;
  logic [WIDTH-1:0] r_work_q, r_work_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] sum;
  logic             no_borrow;
  logic [WIDTH-1:0] q_next, r_next;
  logic             unused_sum_msb;
  // Shifted remainder is WIDTH+1 bits so the MSB pulled from Q never overflows.
  assign shifted        = {r_work_q, q_work_q[WIDTH-1]};
  assign sum            = {1'b0, shifted} + {1'b0, ~{1'b0, d_q}} + (WIDTH+2)'(1);
  assign no_borrow      = sum[WIDTH+1];
  assign unused_sum_msb = sum[WIDTH];
  assign q_next         = {q_work_q[WIDTH-2:0], no_borrow};
  assign r_next         = no_borrow ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      q_work_q <= '0;
      r_work_q <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_work_q <= q_work_d;
      r_work_q <= r_work_d;
      d_q      <= d_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    q_work_d = q_work_q;
    r_work_d = r_work_q;
    d_d      = d_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start && divisor != '0) begin
          q_work_d = dividend;
          r_work_d = '0;
          d_d      = divisor;
          cnt_d    = CW'(WIDTH);
          state_d  = RUN;
        end else if (start) begin
          quo_d   = '1;
          rem_d   = dividend;
          dbz_d   = 1'b1;
          state_d = DONE;
        end
      end
      RUN: begin
        q_work_d = q_next;
        r_work_d = r_next;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          quo_d   = q_next;
          rem_d   = r_next;
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench; driver pushes expectations, negedge monitor checks them.
module tb_seq_restoring_divider;
  localparam int W = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;
  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           cyc;
    int           busy;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, busy_cnt = 0;
  bit rst_at_edge = 1'b1;
  logic [W-1:0] held_q = '0, held_r = '0;
  logic held_z = 1'b0;
  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_at_edge <= !rst_n;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (rst_at_edge) begin
      held_q = '0;
      held_r = '0;
      held_z = 1'b0;
      busy_cnt = 0;
      chk("reset_outputs", {done, busy, quotient, remainder, div_by_zero}, 0);
    end else if (done) begin
      chk("busy_in_done", busy, 0);
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("div_by_zero", div_by_zero, e.z);
        chk("done_cycle", cyc, e.cyc);
        chk("busy_cycles", busy_cnt, e.busy);
        held_q = e.q;
        held_r = e.r;
        held_z = e.z;
      end
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      chk("hold", {quotient, remainder, div_by_zero}, {held_q, held_r, held_z});
    end
  end
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] eq,
                        input logic [W-1:0] er, input logic ez, input bit push);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push) sb.push_back('{eq, er, ez, cyc + (b == '0 ? 0 : W), (b == '0 ? 0 : W)});
  endtask
  task automatic settle();
    repeat (W + 1) @(posedge clk);
    #1;
  endtask
  logic [W-1:0] ta[7] = '{4'd13, 4'd15, 4'd5, 4'd15, 4'd9, 4'd8, 4'd0};
  logic [W-1:0] tb[7] = '{4'd3, 4'd1, 4'd7, 4'd15, 4'd0, 4'd2, 4'd0};
  logic [W-1:0] tq[7] = '{4'd4, 4'd15, 4'd0, 4'd1, 4'd15, 4'd4, 4'd15};
  logic [W-1:0] tr[7] = '{4'd1, 4'd0, 4'd5, 4'd0, 4'd9, 4'd0, 4'd0};
  logic         tz[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      launch(ta[i], tb[i], tq[i], tr[i], tz[i], 1'b1);
      settle();
    end
    launch(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    dividend = 4'd2;
    divisor = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 4'd7;
    divisor = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    launch(4'd14, 4'd4, 4'd0, 4'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    launch(4'd14, 4'd4, 4'd3, 4'd2, 1'b0, 1'b1);
    settle();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(W'(a), W'(b), b == 0 ? 4'hF : W'(a / b), b == 0 ? W'(a) : W'(a % b), b == 0, 1'b1);
        settle();
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
